// File: rtl/poly_key_note_selector.sv
// Polyphonic key scanner with last-note-priority arbitration, per-octave period
// transform and a programmable release tail feeding a square-wave tone generator.
module poly_key_note_selector #(
    parameter int NUM_KEYS       = 8,
    parameter int PERIOD_W       = 19,
    parameter int RELEASE_CYCLES = 1000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_KEYS-1:0]           key_in,
    input  logic [1:0]                    octave_sel,
    input  logic [NUM_KEYS*PERIOD_W-1:0]  base_period,
    output logic [PERIOD_W-1:0]           output_period,
    output logic                          note_active,
    output logic [$clog2(NUM_KEYS)-1:0]   note_idx,
    output logic                          period_changed
);

    localparam int IDX_W = $clog2(NUM_KEYS);
    localparam int CNT_W = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] REL_LOAD =
        (RELEASE_CYCLES > 0) ? CNT_W'(RELEASE_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PLAY,
        ST_REL
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [NUM_KEYS-1:0]   key_prev;
    logic [NUM_KEYS-1:0]   press;
    logic [IDX_W-1:0]      cur_idx;
    logic [IDX_W-1:0]      idx_next;
    logic [CNT_W-1:0]      rel_cnt;
    logic [CNT_W-1:0]      rel_next;
    logic [PERIOD_W-1:0]   period_next;

    function automatic logic [IDX_W-1:0] lowest_set(input logic [NUM_KEYS-1:0] v);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int k = NUM_KEYS - 1; k >= 0; k--) begin
            if (v[k]) r = IDX_W'(k);
        end
        return r;
    endfunction

    function automatic logic [PERIOD_W-1:0] pick_base(
        input logic [NUM_KEYS*PERIOD_W-1:0] tbl,
        input logic [IDX_W-1:0]             idx
    );
        logic [PERIOD_W-1:0] r;
        r = '0;
        for (int k = 0; k < NUM_KEYS; k++) begin
            if (idx == IDX_W'(k)) r = tbl[k*PERIOD_W +: PERIOD_W];
        end
        return r;
    endfunction

    // Doubling the period drops an octave; clamp instead of wrapping to a high note.
    function automatic logic [PERIOD_W-1:0] octave_xform(
        input logic [PERIOD_W-1:0] b,
        input logic [1:0]          sel
    );
        logic [PERIOD_W-1:0] r;
        case (sel)
            2'b11:   r = b;
            2'b01:   r = b >> 1;
            2'b10:   r = b[PERIOD_W-1] ? '1 : (b << 1);
            default: r = '0;
        endcase
        return r;
    endfunction

    always_comb begin
        press    = key_in & ~key_prev;
        idx_next = cur_idx;
        if (|press) begin
            idx_next = lowest_set(press);
        end else if (!key_in[cur_idx] && (|key_in)) begin
            idx_next = lowest_set(key_in);
        end
    end

    always_comb begin
        state_next = state;
        rel_next   = rel_cnt;
        case (state)
            ST_IDLE: begin
                if (|press) state_next = ST_PLAY;
            end
            ST_PLAY: begin
                if (key_in == '0) begin
                    if (RELEASE_CYCLES > 0) begin
                        state_next = ST_REL;
                        rel_next   = REL_LOAD;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            ST_REL: begin
                if (|press) begin
                    state_next = ST_PLAY;
                    rel_next   = '0;
                end else if (rel_cnt == '0) begin
                    state_next = ST_IDLE;
                end else begin
                    rel_next = rel_cnt - 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        period_next = '0;
        if (state_next != ST_IDLE) begin
            period_next = octave_xform(pick_base(base_period, idx_next), octave_sel);
        end
    end

    // rst_n is expected to be released synchronously to clk upstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            key_prev       <= '0;
            cur_idx        <= '0;
            rel_cnt        <= '0;
            output_period  <= '0;
            note_active    <= 1'b0;
            period_changed <= 1'b0;
        end else begin
            state          <= state_next;
            key_prev       <= key_in;
            cur_idx        <= idx_next;
            rel_cnt        <= rel_next;
            output_period  <= period_next;
            note_active    <= (state_next != ST_IDLE);
            period_changed <= (period_next != output_period);
        end
    end

    assign note_idx = cur_idx;

endmodule

// File: doc/poly_key_note_selector.md
Name: poly_key_note_selector

Overview:
- Sequential, parametrised successor to the combinational octave/period mux. Scans NUM_KEYS debounced key levels and applies last-note-priority arbitration.
- Applies a per-octave transform (low/mid/high/mute) to the winning key's base period. Holds the note through a programmable release tail.
- Drives a registered period to the downstream square-wave tone generator.

Parameters:
NUM_KEYS, 8, number of key inputs (2..32)
PERIOD_W, 19, width of each period word
RELEASE_CYCLES, 1000, clocks the last note is held after all keys are released (0 = no tail)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
key_in  input  NUM_KEYS  debounced key levels, 1 = pressed, synchronous to clk
octave_sel  input  2  00 mute, 01 high, 10 low, 11 mid
base_period  input  NUM_KEYS*PERIOD_W  flat table; key k occupies bits [k*PERIOD_W +: PERIOD_W]; quasi-static
output_period  output  PERIOD_W  registered period to tone generator, 0 = silent
note_active  output  1  high in PLAY and RELEASE
note_idx  output  $clog2(NUM_KEYS)  index of current key
period_changed  output  1  one-cycle strobe when output_period changes value

Behaviour:
- Reset (async assert, sync release): state IDLE, key_prev=0, cur_idx=0, rel_cnt=0, output_period=0, note_active=0, note_idx=0, period_changed=0.
- Press detect: press = key_in & ~key_prev; key_prev <= key_in every cycle.
- Arbitration:
  - Any press bit set: cur_idx <= lowest set index of press. A new press always wins, including over a simultaneous release.
  - Otherwise, if key_in[cur_idx]==0 and key_in!=0: cur_idx <= lowest set index of key_in (fallback).
- FSM:
  - IDLE: on press -> PLAY.
  - PLAY:
    - key_in==0 and RELEASE_CYCLES>0 -> RELEASE, load rel_cnt=RELEASE_CYCLES-1.
    - key_in==0 and RELEASE_CYCLES==0 -> IDLE.
  - RELEASE:
    - Any press -> PLAY, counter cleared.
    - Otherwise decrement; at rel_cnt==0 -> IDLE.
    - Tail is exactly RELEASE_CYCLES clocks with note_active=1.
- Period transform, applied to b=base_period[cur_idx] (next-state index):
  - mid: b.
  - high: b>>1.
  - low: b<<1, saturating to all-ones when b[PERIOD_W-1]=1.
  - mute: 0.
- Output register:
  - In PLAY/RELEASE (next state), output_period <= transform; in IDLE <= 0.
  - octave_sel changes take effect on the next edge, including during RELEASE.
- Latency: key press sampled at edge N gives output_period, note_idx and note_active updated at that same edge N. Visible one clock after key_in rises.
- note_idx holds its last value in IDLE.
- period_changed: registered; high for the one cycle following any edge where output_period changed. Not asserted when the value is unchanged, e.g. re-press of the same key.
- Reset mid-note: outputs go to 0 immediately, no tail.
- No storage of press order beyond the current note: fallback is lowest held index, not second-most-recent.

Test Plan:
NUM_KEYS=4, PERIOD_W=19, RELEASE_CYCLES=3; base = {143172, 151685, 170265, 191110} for keys 3..0.
1. Single press, octave 11:
   - key_in 0000->0001 -> next cycle output_period=191110, note_idx=0, note_active=1, period_changed pulse 1 cycle.
   - After release: output holds 191110 exactly 3 cycles, then 0, note_active=0.
2. Octave modes on key 0:
   - octave_sel 01 -> 95555.
   - 10 -> 382220.
   - 00 -> 0 with note_active=1.
   - Set base[0]=300000, sel 10 -> 524287 (saturation).
3. Last-note priority and fallback:
   - Hold key1, then press key3 -> 143172, idx 3.
   - Release key3 with key1 held -> 170265, idx 1, no release tail.
   - Simultaneous press of keys 0 and 2 -> idx 0.
4. Re-press during RELEASE: release all, press key2 on tail cycle 2 -> PLAY, 151685, no 0 gap, tail counter cleared.
5. Async reset: assert rst_n low mid-RELEASE between clock edges -> all outputs 0 immediately. After deassertion with key held, no note until a fresh press edge (key_prev reset to 0 makes the held key register as a press on the first edge -> PLAY).
6. RELEASE_CYCLES=0 variant: release all keys -> output_period=0 on the next edge, note_active=0.
